// File: rtl/sm_nway_pkg.sv
// Shared definitions for the N-way sequencer family: mode encodings, direction
// constants and the binary-to-Gray helper used when SM_NWAY_GRAY_EN is defined.
package sm_nway_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_DONE = 2'd2
    } mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Sized for the widest legal state index (256 states -> 8 bits).
    function automatic logic [7:0] to_gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/sm_nway_dwell_cnt.sv
// Dwell counter: holds while disabled, clears on demand, and flags a step
// once the count has reached the requested dwell.
module sm_nway_dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic               o_step
);

    logic [DWELL_W-1:0] r_cnt;
    logic               w_due;

    // >= rather than == so a dwell lowered mid-count still releases a step.
    assign w_due  = (r_cnt >= i_dwell);
    assign o_step = w_due;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_due) r_cnt <= '0;
            else       r_cnt <= r_cnt + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/sm_nway_seq.sv
// N-state cyclic sequencer with up/down stepping, per-state dwell, parallel load
// and one-shot lap mode. Define SM_NWAY_GRAY_EN to present y Gray-coded.
module sm_nway_seq
    import sm_nway_pkg::*;
#(
    parameter  int NUM_STATES = 4,
    parameter  int DWELL_W    = 8,
    localparam int SW         = $clog2(NUM_STATES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               control,
    input  logic               dir,
    input  logic               oneshot,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               load,
    input  logic [SW-1:0]      load_state,
    output logic [SW-1:0]      y,
    output logic               wrap,
    output logic               done,
    output logic               load_err
);

    localparam logic [SW-1:0] LAST = SW'(NUM_STATES - 1);
    localparam logic [SW-1:0] ONE  = SW'(1);

    if (NUM_STATES < 2 || NUM_STATES > 256) begin : g_range_chk
        $error("sm_nway_seq: NUM_STATES must be in 2..256");
    end

`ifdef SM_NWAY_GRAY_EN
    if ((NUM_STATES & (NUM_STATES - 1)) != 0) begin : g_gray_chk
        $error("sm_nway_seq: Gray output needs a power-of-2 NUM_STATES");
    end
`endif

    function automatic logic [SW-1:0] f_present(input logic [SW-1:0] b);
`ifdef SM_NWAY_GRAY_EN
        return SW'(to_gray(8'(b)));
`else
        return b;
`endif
    endfunction

    mode_t         r_mode;
    logic [SW-1:0] r_bin;
    logic [SW-1:0] r_y;
    logic          r_wrap;
    logic          r_done;
    logic          r_load_err;

    logic          w_run_en;
    logic          w_load_ok;
    logic          w_step_due;
    logic [SW-1:0] w_bin_nxt;
    logic          w_wrap_nxt;

    assign w_run_en  = (r_mode == MODE_RUN) && control;
    assign w_load_ok = load && (load_state <= LAST);

    // Explicit wrap at the ends keeps non-power-of-2 counts inside 0..N-1.
    always_comb begin
        w_bin_nxt  = r_bin;
        w_wrap_nxt = 1'b0;
        if (dir == DIR_DOWN) begin
            w_wrap_nxt = (r_bin == '0);
            w_bin_nxt  = w_wrap_nxt ? LAST : r_bin - ONE;
        end else begin
            w_wrap_nxt = (r_bin == LAST);
            w_bin_nxt  = w_wrap_nxt ? '0 : r_bin + ONE;
        end
    end

    // Any load strobe owns the cycle, so the dwell count freezes on a rejected one.
    sm_nway_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (w_run_en && !load),
        .i_clr   (w_load_ok),
        .i_dwell (dwell),
        .o_step  (w_step_due)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode     <= MODE_IDLE;
            r_bin      <= '0;
            r_y        <= '0;
            r_wrap     <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            if (load) begin
                if (w_load_ok) begin
                    r_bin <= load_state;
                    r_y   <= f_present(load_state);
                    if (r_mode == MODE_DONE) begin
                        r_mode <= MODE_IDLE;
                        r_done <= 1'b0;
                    end
                end else begin
                    r_load_err <= 1'b1;
                end
            end else begin
                case (r_mode)
                    MODE_IDLE: begin
                        if (control) r_mode <= MODE_RUN;
                    end
                    MODE_RUN: begin
                        if (!control) begin
                            r_mode <= MODE_IDLE;
                        end else if (w_step_due) begin
                            r_bin  <= w_bin_nxt;
                            r_y    <= f_present(w_bin_nxt);
                            r_wrap <= w_wrap_nxt;
                            if (oneshot && w_wrap_nxt) begin
                                r_mode <= MODE_DONE;
                                r_done <= 1'b1;
                            end
                        end
                    end
                    MODE_DONE: begin
                        // Leaving DONE needs control low first; it re-enters RUN via IDLE.
                        if (!control) begin
                            r_mode <= MODE_IDLE;
                            r_done <= 1'b0;
                        end
                    end
                    default: begin
                        r_mode <= MODE_IDLE;
                        r_done <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign y        = r_y;
    assign wrap     = r_wrap;
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_sm_nway_seq.sv
// Scoreboard bench for sm_nway_seq: a lap/dwell model predicts each cycle's
// outputs into a queue and a monitor compares them one cycle-edge later.
module tb_sm_nway_seq;

`ifdef SM_NWAY_GRAY_EN
    localparam int N = 8;
`else
    localparam int N = 5;
`endif
    localparam int SW = $clog2(N);
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          control = 1'b0;
    logic          dir = 1'b0;
    logic          oneshot = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic          load = 1'b0;
    logic [SW-1:0] load_state = '0;
    logic [SW-1:0] y;
    logic          wrap;
    logic          done;
    logic          load_err;

    sm_nway_seq #(.NUM_STATES(N), .DWELL_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .control    (control),
        .dir        (dir),
        .oneshot    (oneshot),
        .dwell      (dwell),
        .load       (load),
        .load_state (load_state),
        .y          (y),
        .wrap       (wrap),
        .done       (done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y;
        bit wrap;
        bit done;
        bit err;
        int tag;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference state: position on the ring, cycles spent in the current state,
    // and whether the sequencer is running or has finished a one-shot lap.
    int m_pos = 0;
    int m_cnt = 0;
    bit m_running = 0;
    bit m_finished = 0;

    function automatic int present(input int b);
`ifdef SM_NWAY_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic cyc_drive(input bit r, input bit c, input bit d, input bit o,
                             input int dw, input bit l, input int ls);
        exp_t e;
        @(negedge clk);
        reset = r; control = c; dir = d; oneshot = o;
        dwell = DW'(dw); load = l; load_state = SW'(ls);
        cyc++;
        e.wrap = 0; e.err = 0; e.tag = cyc;
        if (r) begin
            m_pos = 0; m_cnt = 0; m_running = 0; m_finished = 0;
        end else if (l) begin
            if (ls < N) begin
                m_pos = ls; m_cnt = 0;
                m_finished = 0;
            end else begin
                e.err = 1;
            end
        end else if (m_finished) begin
            if (!c) m_finished = 0;
        end else if (!m_running) begin
            if (c) m_running = 1;
        end else if (!c) begin
            m_running = 0;
        end else if (m_cnt >= dw) begin
            m_pos = d ? (m_pos + N - 1) % N : (m_pos + 1) % N;
            m_cnt = 0;
            e.wrap = d ? (m_pos == N - 1) : (m_pos == 0);
            if (o && e.wrap) begin
                m_running = 0;
                m_finished = 1;
            end
        end else begin
            m_cnt++;
        end
        e.y = present(m_pos);
        e.done = m_finished;
        q.push_back(e);
    endtask

    task automatic run(input int n, input bit c, input bit d, input bit o, input int dw);
        for (int i = 0; i < n; i++) cyc_drive(0, c, d, o, dw, 0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (int'(y) !== e.y || wrap !== e.wrap || done !== e.done || load_err !== e.err) begin
                bad++;
                $display("FAIL outputs cyc=%0d actual y=%0d wrap=%b done=%b err=%b required y=%0d wrap=%b done=%b err=%b",
                         e.tag, y, wrap, done, load_err, e.y, e.wrap, e.done, e.err);
            end
`ifndef SM_NWAY_GRAY_EN
            total++;
            if (!(int'(y) < N)) begin
                bad++;
                $display("FAIL range cyc=%0d actual y=%0d required below %0d", e.tag, y, N);
            end
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset then continuous up-count, wrap on the top-to-0 edge.
        cyc_drive(1, 0, 0, 0, 0, 0, 0);
        cyc_drive(1, 1, 0, 0, 0, 0, 0);
        run(12, 1, 0, 0, 0);
        // Down-count with dwell 2.
        cyc_drive(1, 0, 0, 0, 0, 0, 0);
        run(22, 1, 1, 0, 2);
        // Pause mid-dwell keeps the partial count.
        cyc_drive(1, 0, 0, 0, 0, 0, 0);
        run(3, 1, 0, 0, 3);
        run(5, 0, 0, 0, 3);
        run(8, 1, 0, 0, 3);
        // One-shot lap, then control low/high to restart.
        cyc_drive(1, 0, 0, 0, 0, 0, 0);
        run(N + 4, 1, 0, 1, 0);
        run(2, 0, 0, 1, 0);
        run(4, 1, 0, 1, 0);
        // Rejected and accepted loads, the latter on a due step.
        cyc_drive(1, 0, 0, 0, 0, 0, 0);
        run(3, 1, 0, 0, 0);
        cyc_drive(0, 1, 0, 0, 0, 1, 7);
        cyc_drive(0, 1, 0, 0, 0, 1, 2);
        run(3, 1, 0, 0, 0);
        cyc_drive(0, 1, 0, 0, 0, 1, N - 1);
        run(2, 1, 0, 0, 0);
        // Reach DONE, load out of it, reach DONE again, reset with dwell pending.
        run(N + 3, 1, 1, 1, 0);
        cyc_drive(0, 1, 0, 1, 0, 1, 1);
        run(2, 1, 0, 1, 3);
        run(N * 4 + 4, 1, 0, 1, 3);
        cyc_drive(1, 1, 0, 1, 3, 0, 0);
        run(6, 1, 0, 0, 3);
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, c, d, o, l;
            int dw, ls;
            r  = ($urandom_range(0, 99) < 2);
            c  = ($urandom_range(0, 99) < 85);
            d  = ($urandom_range(0, 99) < 30);
            o  = ($urandom_range(0, 99) < 20);
            dw = ($urandom_range(0, 99) < 60) ? 0 : int'($urandom_range(0, 4));
            l  = ($urandom_range(0, 99) < 5);
            ls = int'($urandom_range(0, (1 << SW) - 1));
            cyc_drive(r, c, d, o, dw, l, ls);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sm_nway_seq.md
Name: sm_nway_seq

Overview:
- Parametrised successor to the 4-state control-driven sequencer: N-state cyclic sequencer with up/down direction, per-state dwell count, parallel load and one-shot mode.
- Drives sequencing selects (mux/phase selects) in sandbox FSM designs.
- With NUM_STATES=4, dwell=0, dir=0, oneshot=0, the y sequence is cycle-identical to the original 4-state machine.

Parameters:
- NUM_STATES, 4, number of sequence states; legal range 2..256.
- DWELL_W, 8, width of the dwell input and internal dwell counter.
- SW, $clog2(NUM_STATES), derived width of y; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- control  input  1  run enable; 1 = sequence, 0 = pause.
- dir  input  1  0 = count up, 1 = count down.
- oneshot  input  1  1 = stop after one full lap.
- dwell  input  DWELL_W  extra cycles held in each state; 0 = advance every enabled cycle.
- load  input  1  parallel load strobe.
- load_state  input  SW  value loaded into y.
- y  output  SW  current sequence state, registered.
- wrap  output  1  one-cycle pulse on lap boundary.
- done  output  1  high while in DONE.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- All outputs are registered.
- Reset (sync, dominates everything, including mid-dwell or in DONE):
  - y=0, wrap=0, done=0, load_err=0.
  - dwell counter=0, mode FSM=IDLE.
- Mode FSM states:
  - IDLE: y held. Moves to RUN on control=1.
  - RUN: stepping as below. Moves to IDLE on control=0. Moves to DONE on wrap when oneshot=1.
  - DONE: y held, done=1. Moves to IDLE when control=0. Re-entering RUN requires control to pass through 0.
- Step rule (RUN and control=1 in the same cycle):
  - If cnt >= dwell: y steps, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Comparison is >=, so lowering dwell mid-count causes a step on the next enabled edge.
- Pause: control=0 holds both y and cnt (cnt is not cleared). Resume continues the partial dwell.
- Step direction:
  - Up: y <= (y==NUM_STATES-1) ? 0 : y+1.
  - Down: y <= (y==0) ? NUM_STATES-1 : y-1.
  - Non-power-of-2 NUM_STATES must never produce y >= NUM_STATES.
- wrap: registered, asserted the cycle y becomes 0 (up step) or NUM_STATES-1 (down step). Not asserted on a load.
- Latency: first step occurs dwell+1 enabled edges after entering RUN.
- dir change mid-dwell: takes effect on the next step; cnt is not reset.
- Load (priority above stepping, below reset; accepted in any FSM state):
  - load_state < NUM_STATES: y <= load_state, cnt <= 0, FSM unchanged except DONE -> IDLE.
  - Otherwise: y unchanged, load_err pulses for 1 cycle.
- Simultaneous load and a due step: the load wins, no wrap.

Optional Feature:
- Macro: SM_NWAY_GRAY_EN.
- Defined: y is presented Gray-coded (y = b ^ (b>>1) of the internal binary state), registered, same latency. load_state is still binary; the boundary check is on binary. Only legal when NUM_STATES is a power of 2; otherwise elaboration fails via a generate-time error.
- Undefined: y is binary.

Decomposition:
- Shared package sm_nway_pkg:
  - Mode FSM state encodings MODE_IDLE=2'd0, MODE_RUN=2'd1, MODE_DONE=2'd2.
  - DIR_UP/DIR_DOWN constants.
  - Gray-conversion function.
- Sub-module sm_nway_dwell_cnt: counter with enable, clear and ">= dwell" step output. Reused by later timed-FSM blocks.

Test Plan:
- Reset, control=1, dwell=0, dir=0, N=4 -> y=0,1,2,3,0 on successive edges; wrap high exactly on the 3->0 edge.
- N=5, dwell=2, dir=1, control=1 -> y 0,4 (after 3 edges),3,2,1,0 each held 3 cycles; y never reaches 5..7; wrap on 0->4.
- Dwell=3; drop control after 2 cycles for 5 cycles, then reassert -> y steps after 2 more edges (cnt preserved).
- oneshot=1, N=4, dwell=0 -> y 1,2,3,0, then done=1 with y held at 0; control 1->0->1 -> IDLE then RUN, done=0.
- N=6, load_state=7 -> load_err pulse, y unchanged. load_state=2 on the same cycle a step is due -> y=2, no wrap, cnt=0.
- Assert reset mid-dwell in DONE -> next edge: all outputs 0, FSM IDLE. With SM_NWAY_GRAY_EN, N=8 up-count -> y sequence 0,1,3,2,6,7,5,4.
